// File: rtl/u_dec_stage_if.sv
// Decode-stage bundle: fetch-side handshake, regfile read port and the decoded ALU bundle.
// slave = decode stage view, master = surrounding pipeline view.
interface u_dec_stage_if #(
  parameter int XLEN = 32
);
  logic            ins_vld;
  logic            ins_rdy;
  logic [31:0]     ins;
  logic [XLEN-1:0] pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            dec_vld;
  logic            dec_rdy;
  logic [2:0]      f3;
  logic            f7_b5;
  logic [XLEN-1:0] alu_i1;
  logic [XLEN-1:0] alu_i2;
  logic [4:0]      rd_addr;
  logic            rd_we;
  logic            dec_br;
  logic            dec_ill;

  modport slave (
    input  ins_vld, ins, pc, rs1_data, rs2_data, dec_rdy,
    output ins_rdy, rs1_addr, rs2_addr, dec_vld, f3, f7_b5,
           alu_i1, alu_i2, rd_addr, rd_we, dec_br, dec_ill
  );

  modport master (
    output ins_vld, ins, pc, rs1_data, rs2_data, dec_rdy,
    input  ins_rdy, rs1_addr, rs2_addr, dec_vld, f3, f7_b5,
           alu_i1, alu_i2, rd_addr, rd_we, dec_br, dec_ill
  );
endinterface

// File: rtl/u_dec_stage.sv
// RV32I decode stage: operand/immediate selection into one registered ALU bundle.
// Optional U_DEC_ILLEGAL_CHK_EN enables illegal-encoding detection on dec_ill.
module u_dec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  u_dec_stage_if.slave    bus
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_reg;
  logic [2:0]      f3_reg;
  logic            f7_b5_reg;
  logic [XLEN-1:0] alu_i1_reg;
  logic [XLEN-1:0] alu_i2_reg;
  logic [4:0]      rd_addr_reg;
  logic            rd_we_reg;
  logic            dec_br_reg;
  logic            dec_ill_reg;

  logic [2:0]      f3_next;
  logic            f7_b5_next;
  logic [XLEN-1:0] alu_i1_next;
  logic [XLEN-1:0] alu_i2_next;
  logic            rd_we_next;
  logic            dec_br_next;
  logic            dec_ill_next;

  logic [6:0]      opcode;
  logic [2:0]      f3_in;
  logic [6:0]      f7_in;
  logic [4:0]      rd_in;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic            dec_vld;
  logic            ins_rdy;
  logic            accept;

  assign opcode = bus.ins[6:0];
  assign f3_in  = bus.ins[14:12];
  assign f7_in  = bus.ins[31:25];
  assign rd_in  = bus.ins[11:7];
  assign imm_i  = {{(XLEN-12){bus.ins[31]}}, bus.ins[31:20]};
  assign imm_s  = {{(XLEN-12){bus.ins[31]}}, bus.ins[31:25], bus.ins[11:7]};
  assign imm_u  = {{(XLEN-32){bus.ins[31]}}, bus.ins[31:12], 12'b0};

  assign bus.rs1_addr = bus.ins[19:15];
  assign bus.rs2_addr = bus.ins[24:20];

  assign dec_vld = (state_reg == FULL);
  assign ins_rdy = ~flush & (~dec_vld | bus.dec_rdy);
  assign accept  = bus.ins_vld & ins_rdy;

  always_comb begin
    f3_next      = 3'b000;
    f7_b5_next   = 1'b0;
    alu_i1_next  = bus.rs1_data;
    alu_i2_next  = bus.rs2_data;
    rd_we_next   = 1'b0;
    dec_br_next  = 1'b0;
    dec_ill_next = 1'b0;

    case (opcode)
      OPC_OP: begin
        f3_next    = f3_in;
        f7_b5_next = bus.ins[30];
        rd_we_next = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_i2_next = imm_i;
        f3_next     = f3_in;
        f7_b5_next  = (f3_in == 3'b101) ? bus.ins[30] : 1'b0;
        rd_we_next  = 1'b1;
      end
      OPC_LUI: begin
        alu_i1_next = '0;
        alu_i2_next = imm_u;
        rd_we_next  = 1'b1;
      end
      OPC_AUIPC: begin
        alu_i1_next = bus.pc;
        alu_i2_next = imm_u;
        rd_we_next  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        alu_i1_next = bus.pc;
        alu_i2_next = XLEN'(4);
        rd_we_next  = 1'b1;
      end
      OPC_LOAD: begin
        alu_i2_next = imm_i;
        rd_we_next  = 1'b1;
      end
      OPC_STORE: begin
        alu_i2_next = imm_s;
      end
      OPC_BRANCH: begin
        dec_br_next = 1'b1;
        // Equality compares reuse the subtractor; ordered compares map to SLT/SLTU.
        case (f3_in)
          3'b000, 3'b001: f7_b5_next = 1'b1;
          3'b100, 3'b101: f3_next    = 3'b010;
          3'b110, 3'b111: f3_next    = 3'b011;
          default:        f3_next    = 3'b000;
        endcase
      end
      default: begin
      end
    endcase

`ifdef U_DEC_ILLEGAL_CHK_EN
    case (opcode)
      OPC_OP: begin
        if ((f7_in != 7'h00) && (f7_in != 7'h20))
          dec_ill_next = 1'b1;
        else if ((f7_in == 7'h20) && (f3_in != 3'b000) && (f3_in != 3'b101))
          dec_ill_next = 1'b1;
      end
      OPC_OP_IMM: begin
        if ((f3_in == 3'b001) && (f7_in != 7'h00))
          dec_ill_next = 1'b1;
        else if ((f3_in == 3'b101) && (f7_in != 7'h00) && (f7_in != 7'h20))
          dec_ill_next = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_STORE, OPC_BRANCH: begin
      end
      default: dec_ill_next = 1'b1;
    endcase
    if (bus.ins == 32'h0000_0000)
      dec_ill_next = 1'b1;
    if (dec_ill_next) begin
      rd_we_next  = 1'b0;
      dec_br_next = 1'b0;
    end
`else
    dec_ill_next = 1'b0;
`endif

    if (rd_in == 5'd0)
      rd_we_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= EMPTY;
      f3_reg      <= '0;
      f7_b5_reg   <= 1'b0;
      alu_i1_reg  <= '0;
      alu_i2_reg  <= '0;
      rd_addr_reg <= '0;
      rd_we_reg   <= 1'b0;
      dec_br_reg  <= 1'b0;
      dec_ill_reg <= 1'b0;
    end else if (flush) begin
      state_reg <= EMPTY;
    end else if (accept) begin
      state_reg   <= FULL;
      f3_reg      <= f3_next;
      f7_b5_reg   <= f7_b5_next;
      alu_i1_reg  <= alu_i1_next;
      alu_i2_reg  <= alu_i2_next;
      rd_addr_reg <= rd_in;
      rd_we_reg   <= rd_we_next;
      dec_br_reg  <= dec_br_next;
      dec_ill_reg <= dec_ill_next;
    end else if (dec_vld && bus.dec_rdy) begin
      state_reg <= EMPTY;
    end
  end

  assign bus.ins_rdy = ins_rdy;
  assign bus.dec_vld = dec_vld;
  assign bus.f3      = f3_reg;
  assign bus.f7_b5   = f7_b5_reg;
  assign bus.alu_i1  = alu_i1_reg;
  assign bus.alu_i2  = alu_i2_reg;
  assign bus.rd_addr = rd_addr_reg;
  assign bus.rd_we   = rd_we_reg;
  assign bus.dec_br  = dec_br_reg;
  assign bus.dec_ill = dec_ill_reg;
endmodule
